char_blit_engine: RTL
=====================

Name: char_blit_engine

Overview:
- Inverse of the pixel-to-character split used by the VGA path (pixel H/V → cell scrX/scrY plus in-cell charX/charY).
- Takes one character-cell write request (character code, cell position, colours) and expands it into 128 pixel writes, from 8 columns × 16 rows of glyph bits.
- Each write carries absolute pixel coordinates rebuilt as H = {scrX, charX} and V = {scrY, charY}.
- Sits between the text/console controller (upstream) and the pixel framebuffer write port (downstream), and reads the shared glyph ROM.

Parameters:
- COLOR_W, 12, pixel colour width.
- COLS, 160, number of valid cell columns; scrX must be less than COLS.
- ROWS, 64, number of valid cell rows; scrY must be less than ROWS.
- The cell size is fixed at 8×16 pixels and is not parameterised.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept a request.
- req_char  in  8  character code.
- req_scrX  in  8  cell column.
- req_scrY  in  7  cell row.
- req_fg  in  COLOR_W  foreground colour.
- req_bg  in  COLOR_W  background colour.
- req_transp  in  1  when 1, background pixels are skipped rather than written.
- rom_addr  out  12  glyph ROM address = {char, charY}.
- rom_data  in  8  glyph row; valid 1 cycle after rom_addr; bit 7 is the leftmost pixel.
- pix_valid  out  1  pixel write present.
- pix_ready  in  1  framebuffer accepts the write.
- pix_x  out  11  pixel column = {scrX, charX}.
- pix_y  out  11  pixel row = {scrY, charY}.
- pix_color  out  COLOR_W  pixel colour.
- done  out  1  single-cycle pulse when a character completes.
- err  out  1  single-cycle pulse when a request is rejected.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - req_ready=0 while rst_n=0, then 1 from the first clock edge in IDLE.
  - pix_valid=0, done=0, err=0, rom_addr=0, pix_x=0, pix_y=0, pix_color=0.
  - All counters and latched request fields are cleared.
  - Reset mid-character abandons the character: no further pix_valid and no done pulse.
- States: IDLE → FETCH → LOAD → WRITE → (FETCH | DONE) → IDLE.
- IDLE:
  - req_ready=1 here and only here.
  - A request is accepted on a cycle with req_valid && req_ready; the engine latches char, scrX, scrY, fg, bg and transp, and sets charY=0.
  - If scrX >= COLS or scrY >= ROWS: err pulses on the next cycle, no ROM access, no pixel writes, state stays IDLE.
  - Otherwise go to FETCH.
- FETCH: drive rom_addr = {char, charY} for one cycle.
- LOAD:
  - Capture rom_data into the row register.
  - Set charX=0.
  - Go to WRITE.
- WRITE: current bit b = row[7-charX].
  - If b=1: pix_valid=1, pix_color=fg.
  - If b=0 and transp=0: pix_valid=1, pix_color=bg.
  - If b=0 and transp=1: pix_valid=0; the pixel is skipped and charX advances in that cycle.
  - When pix_valid=1, charX advances only on pix_ready=1. While pix_ready=0, pix_x, pix_y and pix_color hold stable.
  - On leaving charX=7: if charY=15 go to DONE, else charY+1 and go to FETCH.
- DONE: done=1 for one cycle, then IDLE; req_ready returns to 1 on the following cycle.
- Timing:
  - With pix_ready held at 1, each row costs 10 cycles (FETCH, LOAD, 8×WRITE).
  - Acceptance-edge to done-high is 161 cycles, identical with transp=1.
- Arithmetic: coordinates are pure bit concatenation, with no adder and no wrap. Maximum legal pixel is x=1279 (scrX=159, charX=7) and y=1023 (scrY=63, charY=15).
- Requests presented outside IDLE are not accepted; the upstream holds them until req_ready=1.
- rom_addr holds its last value outside FETCH.

Test Plan:
- Reset then req char=0x41, scrX=0, scrY=0, fg=0xFFF, bg=0x000, transp=0; glyph rows all 0x81; pix_ready=1 → 128 writes; (0,0) and (7,0) = 0xFFF; (1..6,0) = 0x000; last write (7,15); done 161 cycles after accept.
- req scrX=159, scrY=63 → first write (1272,1008), last write (1279,1023); rom_addr sequence {char,0}..{char,15}.
- req scrX=160, or scrY=64 → err pulses once; zero pix_valid; req_ready=1 again next cycle.
- transp=1, glyph row 0x80 for every row → exactly 16 writes, all with x=scrX*8 and colour fg; done still at 161 cycles.
- pix_ready toggled 0/1 every cycle → all 128 writes in order; outputs stable during stalls; no write lost or duplicated.
- rst_n asserted mid-character (after 40 writes), then released → pix_valid=0 immediately; no done; a new request produces a full 128-write sequence from (x0,y0).

Source files
------------

// File: rtl/char_blit_engine.sv
// Character-cell blitter: expands one (char, cell, colours) request into 8x16 pixel
// writes, reading one glyph row per scanline from the shared glyph ROM.
module char_blit_engine #(
    parameter int COLOR_W = 12,
    parameter int COLS    = 160,
    parameter int ROWS    = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [7:0]         req_char,
    input  logic [7:0]         req_scrX,
    input  logic [6:0]         req_scrY,
    input  logic [COLOR_W-1:0] req_fg,
    input  logic [COLOR_W-1:0] req_bg,
    input  logic               req_transp,
    output logic [11:0]        rom_addr,
    input  logic [7:0]         rom_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [10:0]        pix_x,
    output logic [10:0]        pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, DONE} state_t;

    // One extra bit so a limit equal to 2**width still compares correctly.
    localparam logic [8:0] COLS_LIM = 9'(COLS);
    localparam logic [7:0] ROWS_LIM = 8'(ROWS);

    state_t               state;
    state_t               state_next;
    logic [7:0]           char_code;
    logic [7:0]           scr_x;
    logic [6:0]           scr_y;
    logic [COLOR_W-1:0]   fg;
    logic [COLOR_W-1:0]   bg;
    logic                 transp;
    logic [2:0]           char_x;
    logic [3:0]           char_y;
    logic [7:0]           row;
    logic                 accept;
    logic                 req_bad;
    logic                 cur_bit;
    logic                 advance;

    assign accept    = req_valid && req_ready;
    assign req_bad   = ({1'b0, req_scrX} >= COLS_LIM) || ({1'b0, req_scrY} >= ROWS_LIM);
    assign cur_bit   = row[3'd7 - char_x];
    assign pix_valid = (state == WRITE) && (cur_bit || !transp);
    assign advance   = (state == WRITE) && (pix_ready || !pix_valid);
    assign pix_x     = {scr_x, char_x};
    assign pix_y     = {scr_y, char_y};
    assign pix_color = cur_bit ? fg : bg;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !req_bad) state_next = FETCH;
            FETCH:   state_next = LOAD;
            LOAD:    state_next = WRITE;
            WRITE: begin
                if (advance && (char_x == 3'd7))
                    state_next = (char_y == 4'd15) ? DONE : FETCH;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // req_ready is registered from the next state so it is high exactly while in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rom_addr  <= '0;
            char_code <= '0;
            scr_x     <= '0;
            scr_y     <= '0;
            fg        <= '0;
            bg        <= '0;
            transp    <= 1'b0;
            char_x    <= '0;
            char_y    <= '0;
            row       <= '0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == IDLE);
            done      <= (state == DONE);
            err       <= accept && req_bad;

            if (accept) begin
                char_code <= req_char;
                scr_x     <= req_scrX;
                scr_y     <= req_scrY;
                fg        <= req_fg;
                bg        <= req_bg;
                transp    <= req_transp;
                char_y    <= 4'd0;
            end

            if (state == IDLE && state_next == FETCH)
                rom_addr <= {req_char, 4'd0};

            if (state == WRITE && state_next == FETCH) begin
                rom_addr <= {char_code, char_y + 4'd1};
                char_y   <= char_y + 4'd1;
            end

            if (state == LOAD) begin
                row    <= rom_data;
                char_x <= 3'd0;
            end

            if (advance && (char_x != 3'd7))
                char_x <= char_x + 3'd1;
        end
    end

endmodule
